// File: rtl/mlp_infer_ctrl_pkg.sv
// Shared constants and FSM state type for the MLP inference controller.
// Widths are fixed by the MLP core that the controller drives.
package mlp_ctrl_pkg;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    localparam int unsigned IN_BITS    = 24;
    localparam int unsigned W_BITS     = 216;
    localparam int unsigned B_BITS     = 63;
    localparam int unsigned OUT_BITS   = 2;
    localparam int unsigned CFG_W      = 8;
    localparam int unsigned PARAM_BITS = W_BITS + B_BITS;
    localparam int unsigned NBYTES     = ceil_div(PARAM_BITS, CFG_W);
    localparam int unsigned PTR_W      = $clog2(NBYTES);
    // Settle counter width covers the legal SETTLE range of 1..15.
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [2:0] {
        StUncfg,
        StLoad,
        StIdle,
        StEval,
        StResult
    } state_e;

endpackage

// File: rtl/mlp_infer_ctrl_if.sv
// Config, input, core and result signals of the MLP inference controller.
// The slave modport is the controller side; master is the surrounding system.
interface mlp_infer_ctrl_if;
    import mlp_ctrl_pkg::*;

    logic                  cfg_start;
    logic                  cfg_valid;
    logic [CFG_W-1:0]      cfg_data;
    logic                  cfg_ready;
    logic                  configured;
    logic                  in_valid;
    logic [IN_BITS-1:0]    in_data;
    logic                  in_ready;
    logic [IN_BITS-1:0]    core_inp;
    logic [W_BITS-1:0]     core_weights;
    logic [B_BITS-1:0]     core_biases;
    logic [OUT_BITS-1:0]   core_out;
    logic                  res_valid;
    logic [OUT_BITS-1:0]   res_class;
    logic                  res_ready;

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data, core_out, res_ready,
        input  cfg_ready, configured, in_ready, core_inp, core_weights, core_biases,
               res_valid, res_class
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, core_out, res_ready,
        output cfg_ready, configured, in_ready, core_inp, core_weights, core_biases,
               res_valid, res_class
    );

endinterface

// File: rtl/mlp_cfg_shift.sv
// Byte-serial parameter loader: byte k lands in params[8k+7:8k], LSB-first.
// Bits beyond PARAM_BITS in the final byte are discarded.
module mlp_cfg_shift
    import mlp_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic [CFG_W-1:0]      data,
    output logic [PARAM_BITS-1:0] params,
    output logic                  last
);

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PARAM_BITS-1:0] params_q, params_d;

    assign last   = (ptr_q == PTR_W'(NBYTES - 1));
    assign params = params_q;

    always_comb begin
        ptr_d    = ptr_q;
        params_d = params_q;
        // Clear has priority so a byte arriving with a restart is dropped.
        if (clr) begin
            ptr_d = '0;
        end else if (load) begin
            for (int i = 0; i < CFG_W; i++) begin
                if (int'(ptr_q) * CFG_W + i < PARAM_BITS) begin
                    params_d[int'(ptr_q) * CFG_W + i] = data[i];
                end
            end
            ptr_d = last ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            params_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            params_q <= params_d;
        end
    end

endmodule

// File: rtl/mlp_infer_ctrl.sv
// Sequencer for the 3-layer argmax MLP core: loads parameters, holds each input
// vector for SETTLE cycles across the core's combinational path, then returns the class.
module mlp_infer_ctrl
    import mlp_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    mlp_infer_ctrl_if.slave bus
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IN_BITS-1:0]    inp_q, inp_d;
    logic [OUT_BITS-1:0]   class_q, class_d;
    logic                  configured_q, configured_d;

    logic                  cfg_clr;
    logic                  cfg_load;
    logic                  cfg_last;
    logic [PARAM_BITS-1:0] params;

    mlp_cfg_shift u_cfg_shift (
        .clk    (clk),
        .rst    (rst),
        .clr    (cfg_clr),
        .load   (cfg_load),
        .data   (bus.cfg_data),
        .params (params),
        .last   (cfg_last)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        inp_d        = inp_q;
        class_d      = class_q;
        configured_d = configured_q;
        cfg_clr      = 1'b0;
        cfg_load     = 1'b0;
        unique case (state_q)
            StUncfg: begin
                if (bus.cfg_start) begin
                    cfg_clr = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (bus.cfg_start) begin
                    cfg_clr = 1'b1;
                end else if (bus.cfg_valid) begin
                    cfg_load = 1'b1;
                    if (cfg_last) begin
                        configured_d = 1'b1;
                        state_d      = StIdle;
                    end
                end
            end
            StIdle: begin
                // A reload request beats a same-cycle input vector.
                if (bus.cfg_start) begin
                    cfg_clr      = 1'b1;
                    configured_d = 1'b0;
                    state_d      = StLoad;
                end else if (bus.in_valid) begin
                    inp_d   = bus.in_data;
                    cnt_d   = '0;
                    state_d = StEval;
                end
            end
            StEval: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    class_d = bus.core_out;
                    state_d = StResult;
                end
            end
            StResult: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StUncfg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StUncfg;
            cnt_q        <= '0;
            inp_q        <= '0;
            class_q      <= '0;
            configured_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            inp_q        <= inp_d;
            class_q      <= class_d;
            configured_q <= configured_d;
        end
    end

    assign bus.cfg_ready    = (state_q == StLoad);
    assign bus.in_ready     = (state_q == StIdle) && !bus.cfg_start;
    assign bus.configured   = configured_q;
    assign bus.core_inp     = inp_q;
    assign bus.core_weights = params[W_BITS-1:0];
    assign bus.core_biases  = params[PARAM_BITS-1:W_BITS];
    assign bus.res_valid    = (state_q == StResult);
    assign bus.res_class    = class_q;

endmodule
